// File: rtl/inv_pipe_pkg.sv
// rtl/inv_pipe_pkg.sv - shared helpers for the invertible-pin elastic pipeline
package inv_pipe_pkg;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/inv_pipe_stage.sv
// rtl/inv_pipe_stage.sv - one valid/data register of the elastic pipeline
module inv_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] dat_q, dat_d;

    // A load beats a clear: the stage hands its word on and takes a new one.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load) begin
            vld_d = 1'b1;
            dat_d = d;
        end else if (clear) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld = vld_q;
    assign dat = dat_q;

endmodule

// File: rtl/inv_elastic_pipe.sv
// rtl/inv_elastic_pipe.sv - bubble-collapsing valid/ready pipeline with invertible pins
module inv_elastic_pipe
    import inv_pipe_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               DEPTH         = 2,
    parameter logic [WIDTH-1:0] INV_IN_DATA   = '0,
    parameter logic             INV_IN_VALID  = 1'b0,
    parameter logic             INV_OUT_READY = 1'b0,
    parameter logic             INV_EN        = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [occ_w(DEPTH)-1:0]    occupancy
);

    localparam int OCC_W = occ_w(DEPTH);

    logic             en_eff, v_eff, r_eff;
    logic [WIDTH-1:0] d_eff;

    assign d_eff  = in_data ^ INV_IN_DATA;
    assign v_eff  = in_valid ^ INV_IN_VALID;
    assign r_eff  = out_ready ^ INV_OUT_READY;
    assign en_eff = en ^ INV_EN;

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] stage_load;
    logic [WIDTH-1:0] dat      [DEPTH];
    logic [WIDTH-1:0] stage_din[DEPTH];

    logic in_xfer, out_xfer;

    // A stage advances when its successor is empty or is itself advancing,
    // so resolve from the output end backwards.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = vld[DEPTH-1] & r_eff & en_eff;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = vld[i] & en_eff & (~vld[i+1] | adv[i+1]);
        end
    end

    assign in_ready  = en_eff & (~vld[0] | adv[0]);
    assign in_xfer   = v_eff & in_ready;
    assign out_valid = vld[DEPTH-1] & en_eff;
    assign out_xfer  = out_valid & r_eff;
    assign out_data  = dat[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign stage_load[g] = in_xfer;
            assign stage_din[g]  = d_eff;
        end else begin : g_body
            assign stage_load[g] = adv[g-1];
            assign stage_din[g]  = dat[g-1];
        end

        inv_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .load  (stage_load[g]),
            .clear (adv[g]),
            .d     (stage_din[g]),
            .vld   (vld[g]),
            .dat   (dat[g])
        );
    end

    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_inv_elastic_pipe.sv
// tb/tb_inv_elastic_pipe.sv - self-checking bench for inv_elastic_pipe
module tb_inv_elastic_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Instance A: DEPTH=2, no inversion
    logic       a_en, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data;
    logic [1:0] a_occ;

    // Instance B: DEPTH=3, no inversion
    logic       b_en, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data;
    logic [1:0] b_occ;

    // Instance C: DEPTH=2, all pins inverted
    logic       c_en, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [7:0] c_in_data, c_out_data;
    logic [1:0] c_occ;

    inv_elastic_pipe #(.WIDTH(8), .DEPTH(2)) u_a (
        .clk(clk), .rst(rst), .en(a_en), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .occupancy(a_occ)
    );

    inv_elastic_pipe #(.WIDTH(8), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .occupancy(b_occ)
    );

    inv_elastic_pipe #(
        .WIDTH(8), .DEPTH(2), .INV_IN_DATA(8'h0F), .INV_IN_VALID(1'b1),
        .INV_OUT_READY(1'b1), .INV_EN(1'b1)
    ) u_c (
        .clk(clk), .rst(rst), .en(c_en), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .occupancy(c_occ)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       en;
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_od;
        logic       chk_od;
        logic [1:0] exp_occ;
    } vec_t;

    vec_t       vecs[12];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] words[3];
    int         lat;
    int         cnt;
    logic       sent3, exp_ir, in_x, out_x;

    initial begin
        // en, v, d, r | in_ready, out_valid, out_data, check_data, occupancy
        vecs[0]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
        vecs[1]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd1};
        vecs[2]  = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 2'd2};
        vecs[3]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 2'd2};
        vecs[4]  = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 2'd2};
        vecs[5]  = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 2'd2};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 2'd1};
        vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 2'd1};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 2'd1};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 2'd1};

        rst = 1'b1;
        a_en = 1'b1; a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
        b_en = 1'b1; b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;
        c_en = 1'b0; c_in_valid = 1'b1; c_in_data = 8'h00; c_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Table vectors on A, starting from the reset state
        for (int i = 0; i < 12; i++) begin
            a_en = vecs[i].en; a_in_valid = vecs[i].v;
            a_in_data = vecs[i].d; a_out_ready = vecs[i].r;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(a_in_ready), 32'(vecs[i].exp_ir));
            chk($sformatf("vec%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d_occ", i), 32'(a_occ), 32'(vecs[i].exp_occ));
            if (vecs[i].chk_od)
                chk($sformatf("vec%0d_out_data", i), 32'(a_out_data), 32'(vecs[i].exp_od));
            @(posedge clk); #1;
        end

        // Reset mid-stream with a transfer in flight
        a_in_valid = 1'b1; a_in_data = 8'h66; a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_in_data = 8'h77; a_out_ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rst_pre_occ", 32'(a_occ), 32'd2);
        @(posedge clk); #1;
        rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_occ", 32'(a_occ), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;

        // Latency on the DEPTH=3 instance
        b_in_valid = 1'b1; b_in_data = 8'hA5;
        @(negedge clk);
        chk("lat_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat_cycles", 32'(lat), 32'd3);
        chk("lat_out_data", 32'(b_out_data), 32'hA5);
        @(posedge clk); #1;
        chk("lat_occ_after", 32'(b_occ), 32'd0);

        // Backpressure on A: two words fill it, the third waits
        words[0] = 8'hC1; words[1] = 8'hC2; words[2] = 8'hC3;
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = words[0];
        @(negedge clk);
        chk("bp_ready0", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_data = words[1];
        @(negedge clk);
        chk("bp_ready1", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        a_in_data = words[2];
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_full_ready", 32'(a_in_ready), 32'd0);
            chk("bp_full_occ", 32'(a_occ), 32'd2);
            chk("bp_hold_data", 32'(a_out_data), 32'hC1);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1; sent3 = 1'b0; got.delete();
        for (int k = 0; k < 20 && got.size() < 3; k++) begin
            @(negedge clk);
            if (a_out_valid && a_out_ready) got.push_back(a_out_data);
            if (a_in_valid && a_in_ready) sent3 = 1'b1;
            @(posedge clk); #1;
            if (sent3) a_in_valid = 1'b0;
        end
        chk("bp_drain_count", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) chk($sformatf("bp_order%0d", k), 32'(got[k]), 32'(words[k]));
        end
        @(negedge clk);
        chk("bp_occ_empty", 32'(a_occ), 32'd0);
        @(posedge clk); #1;

        // Inversion on C: low pins mean valid/ready, data XOR 0x0F
        c_en = 1'b0; c_out_ready = 1'b0; c_in_valid = 1'b0; c_in_data = 8'h00;
        @(negedge clk);
        chk("inv_in_ready", 32'(c_in_ready), 32'd1);
        @(posedge clk); #1;
        c_in_valid = 1'b1;
        lat = 1;
        while (!c_out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("inv_out_valid", 32'(c_out_valid), 32'd1);
        chk("inv_out_data", 32'(c_out_data), 32'h0F);
        @(posedge clk); #1;
        chk("inv_consumed_occ", 32'(c_occ), 32'd0);
        chk("inv_consumed_ov", 32'(c_out_valid), 32'd0);

        // Enable on C: queue two words, freeze with en=1, resume with en=0
        c_out_ready = 1'b1; c_in_valid = 1'b0; c_in_data = 8'h10;
        @(posedge clk); #1;
        c_in_data = 8'h20;
        @(posedge clk); #1;
        c_in_valid = 1'b1; c_en = 1'b1; c_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("en_frozen_ov", 32'(c_out_valid), 32'd0);
            chk("en_frozen_ir", 32'(c_in_ready), 32'd0);
            chk("en_frozen_occ", 32'(c_occ), 32'd2);
            @(posedge clk); #1;
        end
        c_en = 1'b0;
        @(negedge clk);
        chk("en_resume_ov", 32'(c_out_valid), 32'd1);
        chk("en_resume_d0", 32'(c_out_data), 32'h1F);
        @(posedge clk); #1;
        @(negedge clk);
        chk("en_resume_d1", 32'(c_out_data), 32'h2F);
        @(posedge clk); #1;
        @(negedge clk);
        chk("en_resume_occ", 32'(c_occ), 32'd0);
        c_out_ready = 1'b1;
        @(posedge clk); #1;

        // Random streaming on A against a FIFO scoreboard
        cnt = 0; exp_q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            a_en        = ($urandom_range(0, 9) != 0);
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_data   = 8'($urandom);
            a_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_ir = a_en && ((cnt < 2) || a_out_ready);
            chk("st_in_ready", 32'(a_in_ready), 32'(exp_ir));
            chk("st_occ", 32'(a_occ), 32'(cnt));
            if (!a_en) chk("st_ov_frozen", 32'(a_out_valid), 32'd0);
            if (a_out_valid) chk("st_ov_nonempty", 32'(cnt > 0), 32'd1);
            in_x  = a_in_valid && exp_ir;
            out_x = a_out_valid && a_out_ready;
            if (out_x) begin
                if (exp_q.size() == 0) chk("st_underflow", 32'd1, 32'd0);
                else chk("st_data", 32'(a_out_data), 32'(exp_q.pop_front()));
            end
            if (in_x) exp_q.push_back(a_in_data);
            cnt = cnt + int'(in_x) - int'(out_x);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
